// File: rtl/fix_pkg.sv
// fix_pkg: shared constants, record type and FSM encoding for the FIX field extractor.
package fix_pkg;
  localparam int TAG_W = 16;
  localparam int MAX_VAL_LEN = 16;
  localparam int LEN_W = 5;
  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EQ = 8'h3D;
  localparam logic [7:0] DIG0 = 8'h30;
  localparam logic [7:0] DIG9 = 8'h39;
  localparam logic [TAG_W-1:0] TAG_BEGINSTRING = TAG_W'(8);
  localparam logic [TAG_W-1:0] TAG_CHECKSUM = TAG_W'(10);
  typedef enum logic [1:0] {S_IDLE, S_TAG, S_WAIT_VAL, S_VAL} fix_state_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [LEN_W-1:0] len;
    logic [MAX_VAL_LEN*8-1:0] val;
    logic err;
  } fix_field_t;
  function automatic logic is_digit(input logic [7:0] b);
    return b >= DIG0 && b <= DIG9;
  endfunction
  function automatic logic [3:0] digit_val(input logic [7:0] b);
    return 4'(b - DIG0);
  endfunction
endpackage

// File: rtl/fix_field_fifo.sv
// fix_field_fifo: first-word fall-through record FIFO; a push while full is rejected unless a pop frees the slot.
module fix_field_fifo
  import fix_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  fix_field_t wdata_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       valid_o,
  output fix_field_t rdata_o
);
  localparam int AW = $clog2(DEPTH);
  fix_field_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    valid_o = wr_q != rd_q;
    full_o = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    do_pop = pop_i && valid_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    rdata_o = valid_o ? mem_q[rd_q[AW-1:0]] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/fix_field_extractor.sv
// fix_field_extractor: turns fix_parser tag/value segments into binary-tag records queued in a FIFO.
// Define FIX_CHECKSUM_EN to add the running-sum checksum verifier (cks_valid_o / cks_ok_o).
module fix_field_extractor
  import fix_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               data_i,
  input  logic                     tag_s_i,
  input  logic                     tag_e_i,
  input  logic                     value_s_i,
  input  logic                     value_e_i,
  output logic                     fld_valid_o,
  input  logic                     fld_ready_i,
  output logic [TAG_W-1:0]         fld_tag_o,
  output logic [LEN_W-1:0]         fld_len_o,
  output logic [MAX_VAL_LEN*8-1:0] fld_val_o,
  output logic                     fld_err_o,
  output logic [7:0]               drop_cnt_o
`ifdef FIX_CHECKSUM_EN
  ,
  output logic                     cks_valid_o,
  output logic                     cks_ok_o
`endif
);
  localparam int TW = TAG_W + 4;
  fix_state_t state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [MAX_VAL_LEN*8-1:0] val_q, val_d;
  logic err_q, err_d;
  logic [7:0] drop_q, drop_d;
  logic tag_byte, val_byte, done, push, full, pop;
  logic [TW-1:0] acc;
  fix_field_t rec, head;
  always_comb begin
    state_d = state_q;
    tag_d = tag_q;
    len_d = len_q;
    val_d = val_q;
    err_d = err_q;
    tag_byte = 1'b0;
    val_byte = 1'b0;
    push = 1'b0;
    rec = '{tag: tag_q, len: len_q, val: val_q, err: 1'b1};
    // a new tag start always wins; any field still open is flushed as an errored partial
    if (tag_s_i) begin
      push = state_q != S_IDLE;
      tag_d = '0;
      len_d = '0;
      val_d = '0;
      err_d = 1'b0;
      tag_byte = 1'b1;
      state_d = tag_e_i ? S_WAIT_VAL : S_TAG;
    end else if (state_q == S_TAG) begin
      tag_byte = 1'b1;
      state_d = tag_e_i ? S_WAIT_VAL : S_TAG;
    end else if (state_q == S_VAL || (state_q == S_WAIT_VAL && value_s_i)) begin
      val_byte = 1'b1;
      state_d = value_e_i ? S_IDLE : S_VAL;
    end
    done = val_byte && value_e_i;
    acc = TW'(tag_d) * TW'(10) + TW'(digit_val(data_i));
    if (tag_byte && !is_digit(data_i)) err_d = 1'b1;
    else if (tag_byte && acc > TW'({TAG_W{1'b1}})) begin
      tag_d = '1;
      err_d = 1'b1;
    end else if (tag_byte) tag_d = acc[TAG_W-1:0];
    if (val_byte && len_d == LEN_W'(MAX_VAL_LEN)) err_d = 1'b1;
    else if (val_byte) begin
      val_d[8*len_d +: 8] = data_i;
      len_d = len_d + 1'b1;
    end
    if (done) begin
      push = 1'b1;
      rec = '{tag: tag_d, len: len_d, val: val_d, err: err_d};
    end
    drop_d = (push && full && !pop && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      tag_q <= '0;
      len_q <= '0;
      val_q <= '0;
      err_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      len_q <= len_d;
      val_q <= val_d;
      err_q <= err_d;
      drop_q <= drop_d;
    end
  assign pop = fld_valid_o && fld_ready_i;
  fix_field_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .wdata_i(rec),
    .pop_i(pop),
    .full_o(full),
    .valid_o(fld_valid_o),
    .rdata_o(head)
  );
  assign fld_tag_o = head.tag;
  assign fld_len_o = head.len;
  assign fld_val_o = head.val;
  assign fld_err_o = head.err;
  assign drop_cnt_o = drop_q;
`ifdef FIX_CHECKSUM_EN
  logic [7:0] fsum_q, fsum_d, run_q, run_d, total;
  logic cks_valid_q, cks_valid_d, cks_ok_q, cks_ok_d;
  logic [9:0] num;
  always_comb begin
    fsum_d = tag_s_i ? '0 : fsum_q;
    fsum_d = (tag_byte || val_byte) ? fsum_d + data_i : fsum_d;
    total = fsum_d + EQ + SOH;
    num = 10'(digit_val(val_d[7:0])) * 10'd100 + 10'(digit_val(val_d[15:8])) * 10'd10
        + 10'(digit_val(val_d[23:16]));
    run_d = run_q;
    cks_valid_d = 1'b0;
    cks_ok_d = cks_ok_q;
    if (done && tag_d == TAG_BEGINSTRING) run_d = total;
    else if (done && tag_d == TAG_CHECKSUM) begin
      cks_valid_d = 1'b1;
      cks_ok_d = len_d == LEN_W'(3) && is_digit(val_d[7:0]) && is_digit(val_d[15:8])
              && is_digit(val_d[23:16]) && num == 10'(run_q);
    end else if (done) run_d = run_q + total;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fsum_q <= '0;
      run_q <= '0;
      cks_valid_q <= 1'b0;
      cks_ok_q <= 1'b0;
    end else begin
      fsum_q <= fsum_d;
      run_q <= run_d;
      cks_valid_q <= cks_valid_d;
      cks_ok_q <= cks_ok_d;
    end
  assign cks_valid_o = cks_valid_q;
  assign cks_ok_o = cks_ok_q;
`endif
endmodule

// File: tb/tb_fix_field_extractor.sv
// tb_fix_field_extractor: random and directed FIX fields checked against a field-level model and queue FIFO model.
module tb_fix_field_extractor;
  import fix_pkg::*;
  localparam int DEPTH = 4;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    int unsigned tag;
    int unsigned len;
    logic [127:0] val;
    bit err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] data_i;
  logic tag_s_i, tag_e_i, value_s_i, value_e_i, fld_ready_i;
  logic fld_valid_o, fld_err_o;
  logic [TAG_W-1:0] fld_tag_o;
  logic [LEN_W-1:0] fld_len_o;
  logic [MAX_VAL_LEN*8-1:0] fld_val_o;
  logic [7:0] drop_cnt_o;
`ifdef FIX_CHECKSUM_EN
  logic cks_valid_o, cks_ok_o;
`endif
  int checks = 0, failures = 0;
  exp_t mq[$];
  exp_t pend, nil;
  int mdrop = 0;
  bit pend_v = 0, chk_en = 0, rdy_rand = 0, rdy_fix = 0;

  fix_field_extractor #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_i(data_i),
    .tag_s_i(tag_s_i), .tag_e_i(tag_e_i), .value_s_i(value_s_i), .value_e_i(value_e_i),
    .fld_valid_o(fld_valid_o), .fld_ready_i(fld_ready_i), .fld_tag_o(fld_tag_o),
    .fld_len_o(fld_len_o), .fld_val_o(fld_val_o), .fld_err_o(fld_err_o),
    .drop_cnt_o(drop_cnt_o)
`ifdef FIX_CHECKSUM_EN
    , .cks_valid_o(cks_valid_o), .cks_ok_o(cks_ok_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // field-level reference: what record a given tag/value byte string must produce
  function automatic exp_t model(input bq_t tg, input bq_t vl, input bit ab);
    exp_t r;
    longint t;
    t = 0;
    r.err = ab;
    r.val = '0;
    foreach (tg[i]) begin
      if (tg[i] >= 8'h30 && tg[i] <= 8'h39) begin
        t = t * 10 + longint'(tg[i] - 8'h30);
        if (t > 65535) begin
          t = 65535;
          r.err = 1;
        end
      end else r.err = 1;
    end
    r.tag = 32'(t);
    foreach (vl[i]) if (i < 16) r.val[8*i +: 8] = vl[i]; else r.err = 1;
    r.len = (vl.size() > 16) ? 32'd16 : 32'(vl.size());
    return r;
  endfunction

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("valid", 128'(fld_valid_o), 128'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("tag", 128'(fld_tag_o), 128'(mq[0].tag));
      chk("len", 128'(fld_len_o), 128'(mq[0].len));
      chk("val", fld_val_o, mq[0].val);
      chk("err", 128'(fld_err_o), 128'(mq[0].err));
    end
    chk("drop_cnt", 128'(drop_cnt_o), 128'(mdrop));
  end

  task automatic step(input bit ts, input bit te, input bit vs, input bit ve, input logic [7:0] d,
                      input bit p, input exp_t r);
    tag_s_i = ts;
    tag_e_i = te;
    value_s_i = vs;
    value_e_i = ve;
    data_i = d;
    fld_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    @(posedge clk);
    if (fld_ready_i && mq.size() > 0) void'(mq.pop_front());
    if (p && mq.size() < DEPTH) mq.push_back(r);
    else if (p && mdrop < 255) mdrop++;
    #1;
  endtask

  task automatic idle(input int n, input bit spur);
    for (int i = 0; i < n; i++)
      step(0, 0, spur && $urandom_range(0, 3) == 0, 0, 8'($urandom), 0, nil);
  endtask

  // ab: 0 complete, 1 cut inside tag, 2 cut before value, 3 cut inside value
  task automatic send_field(input bq_t tg, input bq_t vl, input int ab);
    exp_t r;
    bq_t vu;
    vu = vl;
    if (ab == 1 || ab == 2) vu.delete();
    r = model(tg, vu, ab != 0);
    for (int i = 0; i < tg.size(); i++)
      step(i == 0, ab != 1 && i == tg.size() - 1, 0, 0, tg[i], i == 0 && pend_v, pend);
    pend_v = 0;
    if (ab == 1) begin
      pend = r;
      pend_v = 1;
      return;
    end
    idle($urandom_range(0, 2), 0);
    if (ab == 2) begin
      pend = r;
      pend_v = 1;
      return;
    end
    for (int i = 0; i < vl.size(); i++)
      step(0, 0, i == 0, ab != 3 && i == vl.size() - 1, vl[i], ab == 0 && i == vl.size() - 1, r);
    if (ab == 3) begin
      pend = r;
      pend_v = 1;
      return;
    end
    idle($urandom_range(0, 2), 1);
  endtask

  task automatic drain();
    rdy_fix = 1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) idle(1, 0);
    rdy_fix = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] all_a;
    bq_t tq, vq;
    exp_t r7;
    int nt, nv, ab;
    tag_s_i = 0; tag_e_i = 0; value_s_i = 0; value_e_i = 0; data_i = 0; fld_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(fld_valid_o), 0);
    chk("rst_tag", 128'(fld_tag_o), 0);
    chk("rst_len", 128'(fld_len_o), 0);
    chk("rst_val", fld_val_o, 0);
    chk("rst_err", 128'(fld_err_o), 0);
    chk("rst_drop", 128'(drop_cnt_o), 0);
    rst = 0;
    chk_en = 1;
    send_field(s2q("35"), s2q("D"), 0);
    @(negedge clk);
    chk("pin35_valid", 128'(fld_valid_o), 1);
    chk("pin35_tag", 128'(fld_tag_o), 35);
    chk("pin35_len", 128'(fld_len_o), 1);
    chk("pin35_byte0", 128'(fld_val_o[7:0]), 128'h44);
    chk("pin35_err", 128'(fld_err_o), 0);
    drain();
    send_field(s2q("3A"), s2q("X"), 0);
    @(negedge clk);
    chk("pin_baddigit_tag", 128'(fld_tag_o), 3);
    chk("pin_baddigit_err", 128'(fld_err_o), 1);
    drain();
    vq.delete();
    for (int i = 0; i < 20; i++) vq.push_back(8'h41);
    send_field(s2q("58"), vq, 0);
    all_a = {16{8'h41}};
    @(negedge clk);
    chk("pin_trunc_len", 128'(fld_len_o), 16);
    chk("pin_trunc_val", fld_val_o, all_a);
    chk("pin_trunc_err", 128'(fld_err_o), 1);
    drain();
    send_field(s2q("99999"), s2q("Z"), 0);
    @(negedge clk);
    chk("pin_sat_tag", 128'(fld_tag_o), 128'hFFFF);
    chk("pin_sat_err", 128'(fld_err_o), 1);
    drain();
    for (int i = 0; i < 6; i++) begin
      vq.delete();
      vq.push_back(8'(8'h61 + i));
      send_field(s2q($sformatf("%0d", i + 1)), vq, 0);
    end
    @(negedge clk);
    chk("pin_overflow_drop", 128'(drop_cnt_o), 2);
    r7 = model(s2q("7"), s2q("g"), 0);
    step(1, 1, 0, 0, 8'h37, 0, nil);
    rdy_fix = 1;
    step(0, 0, 1, 1, 8'h67, 1, r7);
    rdy_fix = 0;
    @(negedge clk);
    chk("pin_full_pushpop_drop", 128'(drop_cnt_o), 2);
    drain();
    send_field(s2q("55"), s2q("xyz"), 3);
    send_field(s2q("58"), s2q("ok"), 0);
    @(negedge clk);
    chk("pin_abort_tag", 128'(fld_tag_o), 55);
    chk("pin_abort_len", 128'(fld_len_o), 3);
    chk("pin_abort_err", 128'(fld_err_o), 1);
    drain();
    rdy_rand = 1;
    for (int f = 0; f < 200; f++) begin
      nt = $urandom_range(1, 6);
      nv = $urandom_range(1, 20);
      ab = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 3);
      tq.delete();
      vq.delete();
      for (int i = 0; i < nt; i++)
        tq.push_back(($urandom_range(0, 15) == 0) ? 8'($urandom_range(33, 126)) : 8'(8'h30 + $urandom_range(0, 9)));
      for (int i = 0; i < nv; i++) vq.push_back(8'($urandom_range(32, 126)));
      send_field(tq, vq, ab);
    end
    send_field(s2q("1"), s2q("x"), 0);
    rdy_rand = 0;
    drain();
    send_field(s2q("12"), s2q("abc"), 0);
    send_field(s2q("13"), s2q("de"), 0);
    step(1, 0, 0, 0, 8'h34, 0, nil);
    chk_en = 0;
    tag_s_i = 0;
    #2 rst = 1;
    #1;
    chk("async_rst_valid", 128'(fld_valid_o), 0);
    chk("async_rst_drop", 128'(drop_cnt_o), 0);
    mq.delete();
    mdrop = 0;
    pend_v = 0;
    @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    send_field(s2q("35"), s2q("D"), 0);
    drain();
`ifdef FIX_CHECKSUM_EN
    send_field(s2q("8"), s2q("A"), 0);
    for (int k = 0; k < 2; k++) begin
      r7 = model(s2q("10"), k == 0 ? s2q("183") : s2q("184"), 0);
      step(1, 0, 0, 0, 8'h31, 0, nil);
      step(0, 1, 0, 0, 8'h30, 0, nil);
      step(0, 0, 1, 0, 8'h31, 0, nil);
      step(0, 0, 0, 0, 8'h38, 0, nil);
      step(0, 0, 0, 1, k == 0 ? 8'h33 : 8'h34, 1, r7);
      chk("cks_valid_pulse", 128'(cks_valid_o), 1);
      chk("cks_ok", 128'(cks_ok_o), k == 0 ? 1 : 0);
      idle(1, 0);
      chk("cks_valid_low", 128'(cks_valid_o), 0);
    end
    drain();
`endif
    for (int f = 0; f < 300; f++) send_field(s2q("1"), s2q("x"), 0);
    @(negedge clk);
    chk("pin_drop_saturate", 128'(drop_cnt_o), 255);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
